// File: rtl/jk_exerciser.sv
// jk_exerciser: runs an eight-step excitation sequence on a JK flip-flop
// with async preset/clear and checks Q against the characteristic table.
module jk_exerciser (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       q_in,
  output logic       j_out,
  output logic       k_out,
  output logic       pr_n,
  output logic       clr_n,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_step,
  output logic [2:0] step
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    FIN
  } state_t;

  state_t state;

  // Packed as {j, k, pr_n, clr_n, expected_q}
  function automatic logic [4:0] vec(input logic [2:0] i);
    logic [4:0] v;
    v = 5'b00110;
    unique case (i)
      3'd0: v = 5'b00100;
      3'd1: v = 5'b00011;
      3'd2: v = 5'b00111;
      3'd3: v = 5'b01110;
      3'd4: v = 5'b10111;
      3'd5: v = 5'b11110;
      3'd6: v = 5'b11111;
      3'd7: v = 5'b00111;
      default: v = 5'b00110;
    endcase
    return v;
  endfunction

  logic [4:0] first_vec;
  logic [4:0] cur_vec;
  logic [4:0] nxt_vec;
  logic       mismatch;

  assign first_vec = vec(3'd0);
  assign cur_vec   = vec(step);
  assign nxt_vec   = vec(step + 3'd1);
  assign mismatch  = (q_in != cur_vec[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      j_out     <= 1'b0;
      k_out     <= 1'b0;
      pr_n      <= 1'b1;
      clr_n     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 4'd0;
      fail_step <= 3'd0;
      step      <= 3'd0;
    end else begin
      unique case (state)
        IDLE, FIN: begin
          // Results settle one cycle after the last check
          if (state == FIN) begin
            done <= 1'b1;
            pass <= (err_count == 4'd0);
          end
          if (start) begin
            state     <= DRIVE;
            step      <= 3'd0;
            j_out     <= first_vec[4];
            k_out     <= first_vec[3];
            pr_n      <= first_vec[2];
            clr_n     <= first_vec[1];
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_step <= 3'd0;
          end
        end
        DRIVE: begin
          state <= CHECK;
          j_out <= 1'b0;
          k_out <= 1'b0;
          pr_n  <= 1'b1;
          clr_n <= 1'b1;
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 4'd1;
            if (err_count == 4'd0)
              fail_step <= step;
          end
          if (step == 3'd7) begin
            state <= FIN;
            busy  <= 1'b0;
          end else begin
            state <= DRIVE;
            step  <= step + 3'd1;
            j_out <= nxt_vec[4];
            k_out <= nxt_vec[3];
            pr_n  <= nxt_vec[2];
            clr_n <= nxt_vec[1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_exerciser.sv
// tb_jk_exerciser: directed runs against a behavioural JK flip-flop model
// with selectable faults; results go through an expectation queue.
module tb_jk_exerciser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       q_in;
  logic       j_out, k_out, pr_n, clr_n;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] fail_step, step;

  jk_exerciser dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .q_in      (q_in),
    .j_out     (j_out),
    .k_out     (k_out),
    .pr_n      (pr_n),
    .clr_n     (clr_n),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_step (fail_step),
    .step      (step)
  );

  always #5 clk = ~clk;

  // 0: good, 1: Q stuck at 0, 2: J=K=1 holds
  int   mode = 0;
  logic q_ff = 1'b0;

  always @(posedge clk or negedge pr_n or negedge clr_n) begin
    if (clr_n === 1'b0)
      q_ff <= 1'b0;
    else if (pr_n === 1'b0)
      q_ff <= 1'b1;
    else if (j_out && k_out)
      q_ff <= (mode == 2) ? q_ff : ~q_ff;
    else if (j_out)
      q_ff <= 1'b1;
    else if (k_out)
      q_ff <= 1'b0;
  end

  assign q_in = (mode == 1) ? 1'b0 : q_ff;

  typedef struct {
    logic [3:0] err;
    logic [2:0] fst;
    logic       ok;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int m, input bit extra,
                     input logic [3:0] e_err, input logic [2:0] e_fst,
                     input logic e_ok);
    int   lat;
    exp_t e;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    sb.push_back('{err: e_err, fst: e_fst, ok: e_ok});
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_clear", {done, pass, err_count, fail_step}, 0);
    check("start_busy", {busy, step}, {1'b1, 3'd0});
    check("step0_drive", {j_out, k_out, pr_n, clr_n}, 4'b0010);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      start = extra && (n == 3 || n == 9);
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    check("done_latency", lat, 17);
    check("final_step", step, 3'd7);
    check("final_busy", busy, 1'b0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("err_count", err_count, e.err);
      check("fail_step", fail_step, e.fst);
      check("pass", pass, e.ok);
    end else begin
      check("sb_empty", sb.size(), 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {busy, done, pass, err_count, fail_step, step}, 0);
    check("rst_drv", {j_out, k_out, pr_n, clr_n}, 4'b0011);
    @(negedge clk);
    rst = 1'b0;

    run(0, 1'b0, 4'd0, 3'd0, 1'b1);
    run(1, 1'b0, 4'd5, 3'd1, 1'b0);
    run(2, 1'b0, 4'd1, 3'd5, 1'b0);
    run(0, 1'b1, 4'd0, 3'd0, 1'b1);

    // reset during CHECK of step 4
    @(negedge clk);
    mode  = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_step", {busy, step}, {1'b1, 3'd4});
    check("mid_drv", {j_out, k_out, pr_n, clr_n}, 4'b0011);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_outs", {busy, done, pass, err_count, fail_step, step}, 0);
    check("abort_drv", {j_out, k_out, pr_n, clr_n}, 4'b0011);
    run(0, 1'b0, 4'd0, 3'd0, 1'b1);

    // rst wins over start
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    check("rst_vs_start", {busy, done, step}, 0);

    // stuck run, then restart with the good model
    run(1, 1'b0, 4'd5, 3'd1, 1'b0);
    run(0, 1'b0, 4'd0, 3'd0, 1'b1);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/jk_exerciser.md
# jk_exerciser

Self-checking sequential exerciser for a JK flip-flop with active-low asynchronous preset and clear. It drives J, K, preset and clear through a fixed eight-step excitation sequence, reads back Q, and compares it against the expected characteristic-table value. It reports a mismatch count, the first failing step and a pass/fail flag. It is the stimulus-and-check counterpart to the JK flip-flop and can be placed next to it in lab builds.

## Interface
- No parameters; sequence length (8) and vectors are fixed.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock, shared with the flip-flop under test.
- rst  in  1  synchronous reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- q_in  in  1  Q output of the flip-flop under test.
- j_out  out  1  J drive.
- k_out  out  1  K drive.
- pr_n  out  1  preset drive, active-low.
- clr_n  out  1  clear drive, active-low.
- busy  out  1  high in DRIVE and CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1; high when err_count=0.
- err_count  out  4  number of mismatching steps in the current or last run.
- fail_step  out  3  index of the first mismatching step; 0 if none.
- step  out  3  current step index.

## Operation
- FSM states: IDLE, DRIVE, CHECK, DONE. All outputs are registered.
- Reset values:
  - State is IDLE.
  - j_out=0, k_out=0, pr_n=1, clr_n=1.
  - busy=0, done=0, pass=0.
  - err_count=0, fail_step=0, step=0.
- Step table (j, k, pr_n, clr_n → expected Q):
  - 0: 0,0,1,0 → 0
  - 1: 0,0,0,1 → 1
  - 2: 0,0,1,1 → 1
  - 3: 0,1,1,1 → 0
  - 4: 1,0,1,1 → 1
  - 5: 1,1,1,1 → 0
  - 6: 1,1,1,1 → 1
  - 7: 0,0,1,1 → 1
- IDLE or DONE with start=1:
  - Go to DRIVE with step=0.
  - Clear err_count, fail_step, done and pass.
- DRIVE: hold the step's vector on j_out, k_out, pr_n and clr_n for exactly one cycle, then go to CHECK.
- CHECK:
  - Drive j_out=0, k_out=0, pr_n=1, clr_n=1 (hold).
  - At the closing edge, compare q_in with the expected value.
  - On a mismatch, increment err_count. If it was 0 before, also load fail_step=step.
- Transitions out of CHECK:
  - step<7: increment step and go to DRIVE.
  - step=7: go to DONE.
- DONE:
  - done=1 and pass=(err_count==0).
  - Results and step=7 are held until start or rst.
- Drives are idle (J=K=0, PR/CLR inactive) in IDLE, CHECK and DONE.
- Ignored inputs:
  - start while busy is ignored.
  - q_in is ignored outside CHECK.
- err_count cannot exceed 8, so there is no saturation logic.

## Timing
- Each step is 2 cycles. A run is 16 cycles from the first DRIVE cycle to the last CHECK cycle.
- Latency:
  - done rises on the edge after the edge that ends CHECK of step 7.
  - With start sampled at edge E0, done is high from edge E0+17.
- Synchronous flip-flop updates: the vector in DRIVE is sampled by the flip-flop at the edge ending DRIVE. Q is then stable for the whole CHECK cycle.
- Asynchronous preset/clear (steps 0 and 1): Q changes during DRIVE and is held through CHECK by J=K=0.
- rst mid-run:
  - At the next edge, return to IDLE with all reset values.
  - Drives are released in the same edge; no partial result survives.
- rst and start in the same cycle: rst wins.
- Restart from DONE: the new run's DRIVE cycle begins on the edge that samples start, and the previous results are cleared at that edge.

## Test plan
- Correct JK model with async PR/CLR, start pulse:
  - done=1 at start+17 cycles.
  - pass=1, err_count=0, fail_step=0.
- q_in stuck at 0:
  - Mismatches at steps 1, 2, 4, 6, 7.
  - err_count=5, fail_step=1, pass=0.
- Faulty model where J=K=1 holds instead of toggling:
  - err_count=1, fail_step=5, pass=0.
- Pulse start again at cycles 3 and 9 of a good run:
  - Both pulses are ignored.
  - done still rises exactly 17 cycles after the first start.
- Assert rst during CHECK of step 4:
  - Next cycle: IDLE, busy=0, step=0, err_count=0.
  - j_out=k_out=0, pr_n=clr_n=1.
  - A subsequent start completes with pass=1.
- Finish a stuck-at-0 run, swap in the good model, pulse start:
  - err_count, done and pass clear on the start edge.
  - The new run ends with pass=1.
